// File: rtl/lcd_window_timing.sv
// lcd_window_timing
//   LCD timing generator for a parallel RGB565 panel with a scaled
//   framebuffer window. Generates active-low HSYNC/VSYNC, DE and pixel
//   colour, and issues read addresses into a synchronous video RAM for a
//   2^WIN_LOG2 square window placed at a runtime-movable origin. Each RAM
//   texel is replicated over 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
//
//   Optional feature macro: LCD_WINDOW_PATTERN_EN
//     defined     -> active pixels outside the window show (x+y) as RGB565
//     not defined -> active pixels outside the window are black
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   win_x/win_y  window origin in active coordinates (sampled once per frame)
//   rd_en        RAM read enable (pixel is inside the window)
//   rd_addr      RAM read address {row, col}; holds while rd_en is low
//   rd_data      RAM read data (RGB565), valid RAM_LAT cycles after rd_addr
//   lcd_hsync    horizontal sync, active low
//   lcd_vsync    vertical sync, active low
//   lcd_de       data enable
//   lcd_r/g/b    pixel colour 5/6/5
//   frame_start  one-cycle pulse on the first output cycle of each frame
//
// All lcd_* outputs and frame_start share a latency of RAM_LAT+2 cycles
// relative to the h/v counters.
module lcd_window_timing #(
  parameter int H_ACTIVE   = 480,
  parameter int H_BP       = 43,
  parameter int H_FP       = 8,
  parameter int H_PULSE    = 4,
  parameter int V_ACTIVE   = 272,
  parameter int V_BP       = 12,
  parameter int V_FP       = 8,
  parameter int V_PULSE    = 4,
  parameter int WIN_LOG2   = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int RAM_LAT    = 1,
  parameter int AW         = 2*(WIN_LOG2-SCALE_LOG2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   win_x,
  input  logic [15:0]   win_y,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  output logic          lcd_hsync,
  output logic          lcd_vsync,
  output logic          lcd_de,
  output logic [4:0]    lcd_r,
  output logic [5:0]    lcd_g,
  output logic [4:0]    lcd_b,
  output logic          frame_start
);

  localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP;
  localparam int CW      = WIN_LOG2 - SCALE_LOG2;

  localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_PULSE_W = 16'(H_PULSE);
  localparam logic [15:0] V_PULSE_W = 16'(V_PULSE);
  localparam logic [15:0] H_DE_LO   = 16'(H_BP);
  localparam logic [15:0] H_DE_HI   = 16'(H_BP + H_ACTIVE);
  localparam logic [15:0] V_DE_LO   = 16'(V_BP);
  localparam logic [15:0] V_DE_HI   = 16'(V_BP + V_ACTIVE);
  localparam logic signed [16:0] WIN_S = 17'(1 << WIN_LOG2);

  // Control word carried alongside the RAM access so it meets rd_data.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        inw;
    logic        fs;
`ifdef LCD_WINDOW_PATTERN_EN
    logic [15:0] pat;
`endif
  } ctl_t;

  logic [15:0] h, v;
  logic [15:0] sx, sy;

  logic [15:0]        x0, y0;
  logic signed [16:0] dx, dy;
  logic               de0, inw0;
  logic [CW-1:0]      col0, row0;
  ctl_t               ctl0, ctl_idle;

  // pipe[0] is aligned with rd_addr, pipe[RAM_LAT] with rd_data.
  ctl_t pipe [RAM_LAT+1];
  ctl_t last;
  logic [15:0] pix;

  // ---------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 16'd1;
    end else begin
      h <= h + 16'd1;
    end
  end

  // Window origin is shadowed once per frame so a mid-frame move never
  // tears the picture.
  always_ff @(posedge clk) begin
    if (reset || (h == '0 && v == '0)) begin
      sx <= win_x;
      sy <= win_y;
    end
  end

  // ---------------------------------------------------------------
  // Stage 0 decode
  // ---------------------------------------------------------------
  always_comb begin
    x0  = h - H_DE_LO;
    y0  = v - V_DE_LO;
    // 17-bit signed offsets: a pixel left of / above the origin is negative
    // rather than aliasing to a large positive value.
    dx  = $signed({1'b0, x0}) - $signed({1'b0, sx});
    dy  = $signed({1'b0, y0}) - $signed({1'b0, sy});
    de0 = (h >= H_DE_LO) && (h < H_DE_HI) && (v >= V_DE_LO) && (v < V_DE_HI);
    inw0 = de0 && !dx[16] && (dx < WIN_S) && !dy[16] && (dy < WIN_S);
    col0 = dx[WIN_LOG2-1:SCALE_LOG2];
    row0 = dy[WIN_LOG2-1:SCALE_LOG2];

    ctl0     = '0;
    ctl0.hs  = (h >= H_PULSE_W);
    ctl0.vs  = (v >= V_PULSE_W);
    ctl0.de  = de0;
    ctl0.inw = inw0;
    ctl0.fs  = (h == '0) && (v == '0);
`ifdef LCD_WINDOW_PATTERN_EN
    ctl0.pat = x0 + y0;
`endif
  end

  always_comb begin
    ctl_idle    = '0;
    ctl_idle.hs = 1'b1;
    ctl_idle.vs = 1'b1;
  end

  // ---------------------------------------------------------------
  // Stage 1: RAM request
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= inw0;
      if (inw0) begin
        rd_addr <= AW'({row0, col0});
      end
    end
  end

  // ---------------------------------------------------------------
  // Control pipeline matching the RAM latency
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= RAM_LAT; i++) begin
        pipe[i] <= ctl_idle;
      end
    end else begin
      pipe[0] <= ctl0;
      for (int unsigned i = 1; i <= RAM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign last = pipe[RAM_LAT];

  // ---------------------------------------------------------------
  // Colour select and output register
  // ---------------------------------------------------------------
  always_comb begin
    pix = '0;
    if (last.inw) begin
      pix = rd_data;
`ifdef LCD_WINDOW_PATTERN_EN
    end else if (last.de) begin
      pix = last.pat;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      lcd_hsync   <= last.hs;
      lcd_vsync   <= last.vs;
      lcd_de      <= last.de;
      lcd_r       <= pix[15:11];
      lcd_g       <= pix[10:5];
      lcd_b       <= pix[4:0];
      frame_start <= last.fs;
    end
  end

endmodule

// File: tb/tb_lcd_window_timing.sv
// Directed bench for lcd_window_timing: default-size instance, a small
// 20x12 raster instance (RAM_LAT=1) and the same raster with RAM_LAT=3.
module tb_lcd_window_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc;
  int   n_vec = 0;
  int   n_err = 0;

  // default instance
  logic [15:0] d_wx, d_wy, d_rd_data;
  logic        d_rd_en, d_hs, d_vs, d_de, d_fs;
  logic [11:0] d_rd_addr;
  logic [4:0]  d_r, d_b;
  logic [5:0]  d_g;

  // small instance, RAM_LAT=1
  logic [15:0] s_wx, s_wy, s_rd_data;
  logic        s_rd_en, s_hs, s_vs, s_de, s_fs;
  logic [1:0]  s_rd_addr;
  logic [4:0]  s_r, s_b;
  logic [5:0]  s_g;

  // small instance, RAM_LAT=3
  logic [15:0] t_wx, t_wy, t_rd_data, t_q1, t_q2;
  logic        t_rd_en, t_hs, t_vs, t_de, t_fs;
  logic [1:0]  t_rd_addr;
  logic [4:0]  t_r, t_b;
  logic [5:0]  t_g;

  lcd_window_timing u_def (
    .clk(clk), .reset(reset), .win_x(d_wx), .win_y(d_wy),
    .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data),
    .lcd_hsync(d_hs), .lcd_vsync(d_vs), .lcd_de(d_de),
    .lcd_r(d_r), .lcd_g(d_g), .lcd_b(d_b), .frame_start(d_fs)
  );

  lcd_window_timing #(
    .H_ACTIVE(16), .H_BP(2), .H_FP(2), .H_PULSE(1),
    .V_ACTIVE(8),  .V_BP(2), .V_FP(2), .V_PULSE(1),
    .WIN_LOG2(2), .SCALE_LOG2(1), .RAM_LAT(1)
  ) u_small (
    .clk(clk), .reset(reset), .win_x(s_wx), .win_y(s_wy),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .lcd_hsync(s_hs), .lcd_vsync(s_vs), .lcd_de(s_de),
    .lcd_r(s_r), .lcd_g(s_g), .lcd_b(s_b), .frame_start(s_fs)
  );

  lcd_window_timing #(
    .H_ACTIVE(16), .H_BP(2), .H_FP(2), .H_PULSE(1),
    .V_ACTIVE(8),  .V_BP(2), .V_FP(2), .V_PULSE(1),
    .WIN_LOG2(2), .SCALE_LOG2(1), .RAM_LAT(3)
  ) u_lat3 (
    .clk(clk), .reset(reset), .win_x(t_wx), .win_y(t_wy),
    .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_data(t_rd_data),
    .lcd_hsync(t_hs), .lcd_vsync(t_vs), .lcd_de(t_de),
    .lcd_r(t_r), .lcd_g(t_g), .lcd_b(t_b), .frame_start(t_fs)
  );

  // RAM models: data = address (tagged 0xF800 for the RAM_LAT=3 instance)
  always @(posedge clk) begin
    d_rd_data <= {4'h0, d_rd_addr};
    s_rd_data <= {14'h0, s_rd_addr};
    t_q1      <= 16'hF800 | {14'h0, t_rd_addr};
    t_q2      <= t_q1;
    t_rd_data <= t_q2;
  end

  // cycle index: 0 = first cycle with reset low (counters at h=0,v=0)
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // running tallies over fixed output windows
  int d_hs_low = 0, s_vs_low = 0, s_fs_cnt = 0, s_fs_2nd = -1;
  int clip_cnt = 0, far_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (cyc >= 3 && cyc <= 533 && !d_hs) d_hs_low = d_hs_low + 1;
      if (cyc >= 3 && cyc <= 242 && !s_vs) s_vs_low = s_vs_low + 1;
      if (s_fs) begin
        s_fs_cnt = s_fs_cnt + 1;
        if (s_fs_cnt == 2) s_fs_2nd = cyc;
      end
      if (cyc >= 721 && cyc <= 960 && s_rd_en) clip_cnt = clip_cnt + 1;
      if (cyc >= 961 && cyc <= 1200 && s_rd_en) far_cnt = far_cnt + 1;
    end
  end

  function automatic logic [15:0] outside_px(input int x, input int y);
`ifdef LCD_WINDOW_PATTERN_EN
    return 16'(x + y);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d, bench did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    d_wx = 16'd0; d_wy = 16'd0;
    s_wx = 16'd4; s_wy = 16'd2;
    t_wx = 16'd4; t_wy = 16'd2;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_s_hsync", s_hs, 1);
    check("rst_s_vsync", s_vs, 1);
    check("rst_s_de", s_de, 0);
    check("rst_s_rgb", {s_r, s_g, s_b}, 0);
    check("rst_s_fs", s_fs, 0);
    check("rst_s_rd_en", s_rd_en, 0);
    check("rst_s_rd_addr", s_rd_addr, 0);
    check("rst_d_de", d_de, 0);
    check("rst_t_hsync", t_hs, 1);
    reset = 1'b0;

    step_to(2);
    check("d_fs_c2", d_fs, 0);
    check("d_hs_idle_c2", d_hs, 1);
    step_to(3);
    check("d_fs_c3", d_fs, 1);
    check("s_fs_c3", s_fs, 1);
    check("t_fs_c3", t_fs, 0);
    check("d_hs_c3", d_hs, 0);
    check("d_vs_c3", d_vs, 0);
    step_to(4);
    check("d_fs_c4", d_fs, 0);
    check("s_fs_c4", s_fs, 0);
    step_to(5);
    check("t_fs_c5", t_fs, 1);
    step_to(6);
    check("d_hs_h3", d_hs, 0);
    step_to(7);
    check("d_hs_h4", d_hs, 1);

    // first DE: counter cycle 42
    step_to(44);
    check("s_de_c44", s_de, 0);
    step_to(45);
    check("s_de_c45", s_de, 1);
    step_to(46);
    check("t_de_c46", t_de, 0);
    step_to(47);
    check("t_de_c47", t_de, 1);

    // blanking pixel h=0,v=3
    step_to(63);
    check("s_hs_blank", s_hs, 0);
    check("s_de_blank", s_de, 0);
    check("s_rgb_blank", {s_r, s_g, s_b}, 0);
    step_to(64);
    check("s_hs_h1", s_hs, 1);

    // x=3,y=1 outside window
    step_to(68);
    check("s_de_x3y1", s_de, 1);
    check("s_rgb_x3y1", {s_r, s_g, s_b}, outside_px(3, 1));

    // row y=2, window origin (4,2)
    step_to(86);
    check("s_rd_en_x3y2", s_rd_en, 0);
    step_to(87);
    check("s_rd_en_x4y2", s_rd_en, 1);
    check("s_rd_addr_x4y2", s_rd_addr, 0);
    step_to(89);
    check("s_rd_addr_x6y2", s_rd_addr, 1);
    check("s_rgb_x4y2", {s_r, s_g, s_b}, 0);
    check("s_de_x4y2", s_de, 1);
    step_to(90);
    check("s_rgb_x5y2", {s_r, s_g, s_b}, 0);
    check("t_rgb_x3y2", {t_r, t_g, t_b}, outside_px(3, 2));
    step_to(91);
    check("s_rgb_x6y2", {s_r, s_g, s_b}, 1);
    check("s_rd_en_x8y2", s_rd_en, 0);
    check("s_rd_addr_hold", s_rd_addr, 1);
    check("t_rgb_x4y2", {t_r, t_g, t_b}, 16'hF800);
    step_to(92);
    check("s_rgb_x7y2", {s_r, s_g, s_b}, 1);
    step_to(93);
    check("s_rgb_x8y2", {s_r, s_g, s_b}, outside_px(8, 2));

    // row y=4
    step_to(127);
    check("s_rd_en_x4y4", s_rd_en, 1);
    check("s_rd_addr_x4y4", s_rd_addr, 2);
    step_to(129);
    check("s_rgb_x4y4", {s_r, s_g, s_b}, 2);
    check("s_rd_addr_x6y4", s_rd_addr, 3);
    step_to(130);
    check("s_rgb_x5y4", {s_r, s_g, s_b}, 2);
    step_to(131);
    check("s_rgb_x6y4", {s_r, s_g, s_b}, 3);
    step_to(132);
    check("s_rgb_x7y4", {s_r, s_g, s_b}, 3);
    step_to(167);
    check("s_rd_en_x4y6", s_rd_en, 0);

    // frame 1: move origin to x=8 on line 3
    step_to(300);
    s_wx = 16'd8;
    step_to(327);
    check("f1_rd_en_x4y2", s_rd_en, 1);
    check("f1_rd_addr_x4y2", s_rd_addr, 0);
    step_to(367);
    check("f1_rd_en_x4y4", s_rd_en, 1);
    step_to(371);
    check("f1_rd_en_x8y4", s_rd_en, 0);

    // frame 2: origin x=8 in effect
    step_to(567);
    check("f2_rd_en_x4y2", s_rd_en, 0);
    step_to(571);
    check("f2_rd_en_x8y2", s_rd_en, 1);
    check("f2_rd_addr_x8y2", s_rd_addr, 0);
    step_to(574);
    check("f2_rd_addr_x11y2", s_rd_addr, 1);
    step_to(575);
    check("f2_rd_en_x12y2", s_rd_en, 0);
    check("f2_rgb_x10y2", {s_r, s_g, s_b}, 1);

    // frame 3: clipped at the right edge
    step_to(580);
    s_wx = 16'd14;
    step_to(817);
    check("f3_rd_en_x14y2", s_rd_en, 1);
    step_to(818);
    check("f3_rd_en_x15y2", s_rd_en, 1);
    check("f3_rd_addr_x15y2", s_rd_addr, 0);
    step_to(819);
    check("f3_rd_en_h18", s_rd_en, 0);
    step_to(857);
    check("f3_rd_addr_x14y4", s_rd_addr, 2);
    step_to(859);
    check("f3_rgb_x14y4", {s_r, s_g, s_b}, 2);

    // frame 4: origin beyond the active width
    step_to(900);
    s_wx = 16'd100;
    step_to(1205);

    check("d_hsync_low_per_line", d_hs_low, 4);
    check("s_vsync_low_per_frame", s_vs_low, 20);
    check("s_fs_second", s_fs_2nd, 243);
    check("s_fs_count", s_fs_cnt, 6);
    check("f3_clip_rd_count", clip_cnt, 8);
    check("f4_far_rd_count", far_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
